// File: rtl/exec_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : exec_mem_stage
// Brief    : EX->MEM pipeline register with stall/flush, S/Z/C/V flags,
//            branch resolution and a scanned N-digit 7-segment hex display.
// Revision : 1.0
// ============================================================================
module exec_mem_stage #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 3,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [3:0]            flag_in,
    input  logic                  flag_we,
    input  logic                  write_reg,
    input  logic [REG_AW-1:0]     reg_addr,
    input  logic [1:0]            mem_op,
    input  logic [DATA_W-1:0]     addr_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic                  is_branch,
    input  logic [2:0]            cond,
    input  logic [DATA_W-1:0]     branch_target,
    input  logic                  disp_we,
    input  logic [4*DIGITS-1:0]   disp_data,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     alu_out,
    output logic                  write_reg_out,
    output logic [REG_AW-1:0]     reg_addr_out,
    output logic [DATA_W-1:0]     addr_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic                  read_en,
    output logic                  write_en,
    output logic                  pcsrc,
    output logic [DATA_W-1:0]     pc_target,
    output logic [3:0]            flags_q,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int c_CNT_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic                  w_cap;
    logic                  w_load;
    logic                  w_taken;
    logic [4*DIGITS-1:0]   r_latch;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0]   w_shift;
    logic [3:0]            w_nib;

    assign w_cap  = in_valid & ~flush;
    // A flush must insert its bubble even while the stage is stalled.
    assign w_load = ~stall | flush;

    // Conditions look only at flags committed by earlier instructions.
    always_comb begin
        w_taken = 1'b0;
        case (cond)
            3'd0:    w_taken = 1'b1;
            3'd1:    w_taken = flags_q[2];
            3'd2:    w_taken = flags_q[3] ^ flags_q[0];
            3'd3:    w_taken = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'd4:    w_taken = ~flags_q[2];
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            alu_out        <= '0;
            write_reg_out  <= 1'b0;
            reg_addr_out   <= '0;
            addr_out       <= '0;
            store_data_out <= '0;
            read_en        <= 1'b0;
            write_en       <= 1'b0;
            pcsrc          <= 1'b0;
            pc_target      <= '0;
            flags_q        <= '0;
            r_latch        <= '0;
        end else if (w_load) begin
            out_valid      <= w_cap;
            alu_out        <= alu_result;
            write_reg_out  <= write_reg & w_cap;
            reg_addr_out   <= reg_addr;
            addr_out       <= addr_in;
            store_data_out <= store_data_in;
            read_en        <= w_cap & (mem_op == 2'd1);
            write_en       <= w_cap & (mem_op == 2'd2);
            pcsrc          <= w_cap & is_branch & w_taken;
            pc_target      <= branch_target;
            if (w_cap && flag_we) begin
                flags_q <= flag_in;
            end
            if (w_cap && disp_we) begin
                r_latch <= disp_data;
            end
        end
    end

    // Digit scanning is free-running and ignores pipeline control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_shift   = r_latch >> {r_idx, 2'b00};
    assign w_nib     = w_shift[3:0];
    assign digit_sel = DIGITS'(1) << r_idx;

    always_comb begin
        seg = 8'h00;
        case (w_nib)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h1A;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            4'hF: seg = 8'h8E;
            default: seg = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_mem_stage
// Brief    : Directed + random bench for exec_mem_stage with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_exec_mem_stage;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                stall, flush, in_valid, flag_we, write_reg, is_branch, disp_we;
    logic [DATA_W-1:0]   alu_result, addr_in, store_data_in, branch_target;
    logic [3:0]          flag_in;
    logic [REG_AW-1:0]   reg_addr;
    logic [1:0]          mem_op;
    logic [2:0]          cond;
    logic [4*DIGITS-1:0] disp_data;
    logic                out_valid, write_reg_out, read_en, write_en, pcsrc;
    logic [DATA_W-1:0]   alu_out, addr_out, store_data_out, pc_target;
    logic [REG_AW-1:0]   reg_addr_out;
    logic [3:0]          flags_q;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   digit_sel;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic                m_valid, m_wr, m_rd, m_we, m_pcsrc;
    logic [DATA_W-1:0]   m_alu, m_addr, m_sd, m_pct;
    logic [REG_AW-1:0]   m_ra;
    logic [3:0]          m_flags;
    logic [4*DIGITS-1:0] m_latch;
    int                  scan_t;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    exec_mem_stage #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_result(alu_result), .flag_in(flag_in), .flag_we(flag_we),
        .write_reg(write_reg), .reg_addr(reg_addr), .mem_op(mem_op), .addr_in(addr_in),
        .store_data_in(store_data_in), .is_branch(is_branch), .cond(cond),
        .branch_target(branch_target), .disp_we(disp_we), .disp_data(disp_data),
        .out_valid(out_valid), .alu_out(alu_out), .write_reg_out(write_reg_out),
        .reg_addr_out(reg_addr_out), .addr_out(addr_out), .store_data_out(store_data_out),
        .read_en(read_en), .write_en(write_en), .pcsrc(pcsrc), .pc_target(pc_target),
        .flags_q(flags_q), .seg(seg), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
        logic s, z, v;
        s = f[3]; z = f[2]; v = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return s != v;
            3'd3: return z || (s != v);
            3'd4: return !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_rd = 0; m_we = 0; m_pcsrc = 0;
        m_alu = '0; m_addr = '0; m_sd = '0; m_pct = '0; m_ra = '0;
        m_flags = '0; m_latch = '0; scan_t = 0;
    endtask

    task automatic check_all(input string tag);
        int dig;
        logic [3:0] nib;
        dig = (scan_t / SCAN_DIV) % DIGITS;
        nib = 4'((m_latch >> (4 * dig)) & 16'hF);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".alu_out"}, 32'(alu_out), 32'(m_alu));
        chk({tag, ".write_reg_out"}, 32'(write_reg_out), 32'(m_wr));
        chk({tag, ".reg_addr_out"}, 32'(reg_addr_out), 32'(m_ra));
        chk({tag, ".addr_out"}, 32'(addr_out), 32'(m_addr));
        chk({tag, ".store_data_out"}, 32'(store_data_out), 32'(m_sd));
        chk({tag, ".read_en"}, 32'(read_en), 32'(m_rd));
        chk({tag, ".write_en"}, 32'(write_en), 32'(m_we));
        chk({tag, ".pcsrc"}, 32'(pcsrc), 32'(m_pcsrc));
        chk({tag, ".pc_target"}, 32'(pc_target), 32'(m_pct));
        chk({tag, ".flags_q"}, 32'(flags_q), 32'(m_flags));
        chk({tag, ".digit_sel"}, 32'(digit_sel), 32'(1 << dig));
        chk({tag, ".seg"}, 32'(seg), 32'(seg_tab[nib]));
    endtask

    task automatic rand_inputs(input int stall_pct, input int flush_pct);
        stall         = ($urandom_range(0, 99) < stall_pct);
        flush         = ($urandom_range(0, 99) < flush_pct);
        in_valid      = 1'($urandom);
        alu_result    = DATA_W'($urandom);
        flag_in       = 4'($urandom);
        flag_we       = 1'($urandom);
        write_reg     = 1'($urandom);
        reg_addr      = REG_AW'($urandom);
        mem_op        = 2'($urandom);
        addr_in       = DATA_W'($urandom);
        store_data_in = DATA_W'($urandom);
        is_branch     = 1'($urandom);
        cond          = 3'($urandom);
        branch_target = DATA_W'($urandom);
        disp_we       = ($urandom_range(0, 9) == 0);
        disp_data     = (4*DIGITS)'($urandom);
    endtask

    // Clean valid instruction with no side effects other than what the caller sets.
    task automatic quiet_instr();
        rand_inputs(0, 0);
        in_valid = 1; flag_we = 0; is_branch = 0; disp_we = 0;
    endtask

    // Apply the current inputs across one rising edge and compare afterwards.
    task automatic tick(input string tag);
        logic cap;
        @(posedge clk);
        if (!stall || flush) begin
            cap      = in_valid && !flush;
            m_valid  = cap;
            m_wr     = cap && write_reg;
            m_rd     = cap && (mem_op == 2'd1);
            m_we     = cap && (mem_op == 2'd2);
            m_pcsrc  = cap && is_branch && cond_true(cond, m_flags);
            m_alu    = alu_result;
            m_ra     = reg_addr;
            m_addr   = addr_in;
            m_sd     = store_data_in;
            m_pct    = branch_target;
            if (cap && flag_we) m_flags = flag_in;
            if (cap && disp_we) m_latch = disp_data;
        end
        scan_t++;
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        rand_inputs(0, 0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1;

        // Memory write, then mem_op=3
        quiet_instr(); mem_op = 2'd2; addr_in = 16'h0040; store_data_in = 16'h1234;
        tick("store");
        chk("store.write_en_direct", 32'(write_en), 32'd1);
        quiet_instr(); mem_op = 2'd3;
        tick("memop3");
        quiet_instr(); mem_op = 2'd1;
        tick("load");

        // Clear flags, then same-cycle flag write + branch must use old flags
        quiet_instr(); flag_we = 1; flag_in = 4'b0000;
        tick("flags_clr");
        quiet_instr(); flag_we = 1; flag_in = 4'b0100; is_branch = 1; cond = 3'd1;
        tick("br_same_cycle");
        chk("br_same_cycle.pcsrc_direct", 32'(pcsrc), 32'd0);
        quiet_instr(); is_branch = 1; cond = 3'd1;
        tick("br_z_taken");
        chk("br_z_taken.pcsrc_direct", 32'(pcsrc), 32'd1);
        quiet_instr(); is_branch = 1; cond = 3'd4;
        tick("br_nz");

        // Signed-less-than conditions
        quiet_instr(); flag_we = 1; flag_in = 4'b1001;
        tick("flags_sv");
        quiet_instr(); is_branch = 1; cond = 3'd2;
        tick("br_lt_sv11");
        quiet_instr(); flag_we = 1; flag_in = 4'b1000;
        tick("flags_s");
        quiet_instr(); is_branch = 1; cond = 3'd2;
        tick("br_lt_s1v0");
        quiet_instr(); is_branch = 1; cond = 3'd6;
        tick("br_cond6");
        quiet_instr(); is_branch = 1; cond = 3'd3;
        tick("br_le");

        // Stall holds everything; flush+stall inserts a bubble
        quiet_instr(); write_reg = 1; mem_op = 2'd1; is_branch = 1; cond = 3'd0;
        tick("pre_stall");
        for (int i = 0; i < 3; i++) begin
            rand_inputs(100, 0);
            tick("stall");
        end
        rand_inputs(100, 100);
        in_valid = 1; write_reg = 1; mem_op = 2'd2; is_branch = 1; cond = 3'd0;
        tick("flush_stall");
        chk("flush_stall.out_valid_direct", 32'(out_valid), 32'd0);

        // Display: load BEEF and watch a few full scan rotations
        quiet_instr(); disp_we = 1; disp_data = 16'hBEEF;
        tick("disp_load");
        for (int i = 0; i < 20; i++) begin
            rand_inputs(30, 10); disp_we = 0;
            tick("scan");
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs(25, 15);
            tick("rand");
        end

        // Asynchronous reset mid-scan with non-zero flags
        quiet_instr(); flag_we = 1; flag_in = 4'b1010;
        tick("flags_pre_rst");
        quiet_instr();
        tick("pre_rst");
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            rand_inputs(20, 10);
            tick("post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
